dm_arbiter: RTL and testbench

DM_ARBITER -- requirements
Module: dm_arbiter

---
 rtl/dm_arbiter_pkg.sv | 20 ++
 rtl/dm_arbiter_arb_rr2.sv | 23 ++
 rtl/dm_arbiter.sv | 152 +++++++++++++++
 tb/tb_dm_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_arbiter_pkg.sv
// Shared definitions for the two-port data-memory arbiter: FSM encoding,
// port indices and a small one-hot helper.
package dm_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } dm_state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    // Completion pulse vector for a given port index, bit p set.
    function automatic logic [1:0] port_onehot(input logic p);
        return (p == PORT1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/dm_arbiter_arb_rr2.sv
// Two-requester grant selection: round-robin against the previous winner,
// or fixed priority to port 0 when rr is low.
module arb_rr2
    import dm_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       rr,
    output logic       grant,
    output logic       valid
);

    always_comb begin
        valid = |req;
        grant = PORT0;
        if (req == 2'b11) begin
            grant = rr ? ~last : PORT0;
        end else if (req[1]) begin
            grant = PORT1;
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port arbiter in front of a single data memory with RD_LAT-cycle read
// latency; one transaction in flight, all outputs registered except o_BUSY.
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int RR     = 1
) (
    input  logic        inclk,
    input  logic        rstn,
    input  logic        i_REQ0,
    input  logic        i_W0,
    input  logic [31:0] i_ADDR0,
    input  logic [31:0] i_WDATA0,
    input  logic        i_REQ1,
    input  logic        i_W1,
    input  logic [31:0] i_ADDR1,
    input  logic [31:0] i_WDATA1,
    output logic        o_ACK0,
    output logic [31:0] o_RDATA0,
    output logic        o_ACK1,
    output logic [31:0] o_RDATA1,
    output logic        DM_CS,
    output logic        DM_R,
    output logic        DM_W,
    output logic [31:0] o_DM_addr,
    output logic [31:0] o_DM_wdata,
    input  logic [31:0] i_DM_rdata,
    output logic        o_BUSY
);

    // Counter is loaded with RD_LAT-1 so WAIT spans exactly RD_LAT cycles.
    localparam logic [1:0] WAIT_LOAD = 2'(RD_LAT - 1);

    dm_state_t   state_reg;
    logic        last_reg;
    logic        port_reg;
    logic        w_reg;
    logic        cs_reg;
    logic        rd_reg;
    logic        wr_reg;
    logic [1:0]  cnt_reg;
    logic [1:0]  ack_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [31:0] rdata0_reg;
    logic [31:0] rdata1_reg;

    logic        grant_idx;
    logic        grant_valid;
    logic        sel_w;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;

    arb_rr2 u_arb (
        .req   ({i_REQ1, i_REQ0}),
        .last  (last_reg),
        .rr    (RR != 0),
        .grant (grant_idx),
        .valid (grant_valid)
    );

    always_comb begin
        sel_w     = i_W0;
        sel_addr  = i_ADDR0;
        sel_wdata = i_WDATA0;
        if (grant_idx == PORT1) begin
            sel_w     = i_W1;
            sel_addr  = i_ADDR1;
            sel_wdata = i_WDATA1;
        end
    end

    always_ff @(posedge inclk) begin
        if (!rstn) begin
            state_reg  <= IDLE;
            last_reg   <= PORT1;
            port_reg   <= PORT0;
            w_reg      <= 1'b0;
            cs_reg     <= 1'b0;
            rd_reg     <= 1'b0;
            wr_reg     <= 1'b0;
            cnt_reg    <= 2'd0;
            ack_reg    <= 2'b00;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            rdata0_reg <= '0;
            rdata1_reg <= '0;
        end else begin
            // Strobes and ACKs are single-cycle; re-asserted only on entry.
            cs_reg  <= 1'b0;
            rd_reg  <= 1'b0;
            wr_reg  <= 1'b0;
            ack_reg <= 2'b00;
            case (state_reg)
                IDLE: begin
                    if (grant_valid) begin
                        port_reg  <= grant_idx;
                        last_reg  <= grant_idx;
                        w_reg     <= sel_w;
                        addr_reg  <= sel_addr;
                        wdata_reg <= sel_wdata;
                        cs_reg    <= 1'b1;
                        rd_reg    <= ~sel_w;
                        wr_reg    <= sel_w;
                        state_reg <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (w_reg) begin
                        ack_reg   <= port_onehot(port_reg);
                        state_reg <= DONE;
                    end else begin
                        cnt_reg   <= WAIT_LOAD;
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_reg == 2'd0) begin
                        if (port_reg == PORT1) begin
                            rdata1_reg <= i_DM_rdata;
                        end else begin
                            rdata0_reg <= i_DM_rdata;
                        end
                        ack_reg   <= port_onehot(port_reg);
                        state_reg <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg - 2'd1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign o_ACK0     = ack_reg[0];
    assign o_ACK1     = ack_reg[1];
    assign o_RDATA0   = rdata0_reg;
    assign o_RDATA1   = rdata1_reg;
    assign DM_CS      = cs_reg;
    assign DM_R       = rd_reg;
    assign DM_W       = wr_reg;
    assign o_DM_addr  = addr_reg;
    assign o_DM_wdata = wdata_reg;
    assign o_BUSY     = (state_reg != IDLE);

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: three configurations (RR/LAT1, fixed/LAT1, RR/LAT3)
// driven by the same directed stimulus, each checked against a schedule model.
module tb_dm_arbiter;

    localparam int N = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        req0, req1, w0, w1;
    logic [31:0] addr0, addr1, wdata0, wdata1;

    logic [N-1:0]       ack0_v, ack1_v, cs_v, r_v, w_v, busy_v;
    logic [N-1:0][31:0] rdata0_v, rdata1_v, dm_addr_v, dm_wdata_v;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int inst,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d cyc%0d: got 0x%08h expected 0x%08h",
                     name, inst, cyc, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input int inst,
                             input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d cyc%0d: got %b expected %b",
                     name, inst, cyc, act, exp);
        end
    endtask

    for (genvar gi = 0; gi < N; gi++) begin : g_inst
        localparam int P_RR  = (gi == 1) ? 0 : 1;
        localparam int P_LAT = (gi == 2) ? 3 : 1;

        logic        ack0, ack1, cs, rd, wr, busy;
        logic [31:0] rdata0, rdata1, dm_addr, dm_wdata;
        logic [31:0] dm_rdata = 32'h0;

        dm_arbiter #(.RD_LAT(P_LAT), .RR(P_RR)) u_dut (
            .inclk      (clk),
            .rstn       (rstn),
            .i_REQ0     (req0),
            .i_W0       (w0),
            .i_ADDR0    (addr0),
            .i_WDATA0   (wdata0),
            .i_REQ1     (req1),
            .i_W1       (w1),
            .i_ADDR1    (addr1),
            .i_WDATA1   (wdata1),
            .o_ACK0     (ack0),
            .o_RDATA0   (rdata0),
            .o_ACK1     (ack1),
            .o_RDATA1   (rdata1),
            .DM_CS      (cs),
            .DM_R       (rd),
            .DM_W       (wr),
            .o_DM_addr  (dm_addr),
            .o_DM_wdata (dm_wdata),
            .i_DM_rdata (dm_rdata),
            .o_BUSY     (busy)
        );

        assign ack0_v[gi]     = ack0;
        assign ack1_v[gi]     = ack1;
        assign cs_v[gi]       = cs;
        assign r_v[gi]        = rd;
        assign w_v[gi]        = wr;
        assign busy_v[gi]     = busy;
        assign rdata0_v[gi]   = rdata0;
        assign rdata1_v[gi]   = rdata1;
        assign dm_addr_v[gi]  = dm_addr;
        assign dm_wdata_v[gi] = dm_wdata;

        // Memory: read data is valid only RD_LAT cycles after the read strobe.
        logic [31:0] mem [logic [31:0]];
        logic        rd_pend = 1'b0;
        int          rd_issue = 0;
        logic [31:0] rd_addr = 32'h0;
        always @(negedge clk) begin
            if (rd_pend && cyc == rd_issue + P_LAT)
                dm_rdata = mem.exists(rd_addr) ? mem[rd_addr] : (rd_addr ^ 32'h5A5A_0000);
            else
                dm_rdata = 32'hBAD0_0000 | 32'(cyc);
            if (cs && wr) mem[dm_addr] = dm_wdata;
            if (cs && rd) begin
                rd_pend  = 1'b1;
                rd_issue = cyc;
                rd_addr  = dm_addr;
            end
        end

        // Transaction schedule model: one transaction at a time with known
        // access and completion cycles.
        logic        m_active = 1'b0, m_last = 1'b1, m_port = 1'b0, m_w = 1'b0;
        logic [31:0] m_addr = 32'h0, m_wdata = 32'h0;
        logic [31:0] m_rd [2];
        int          m_acc = 0, m_ack = 0;
        always @(posedge clk) begin
            int k;
            k = cyc;
            if (!rstn) begin
                m_active = 1'b0;
                m_last   = 1'b1;
                m_port   = 1'b0;
                m_w      = 1'b0;
                m_addr   = 32'h0;
                m_wdata  = 32'h0;
                m_rd[0]  = 32'h0;
                m_rd[1]  = 32'h0;
            end else if (m_active) begin
                if (!m_w && k == m_ack - 1) m_rd[m_port] = dm_rdata;
                if (k == m_ack) m_active = 1'b0;
            end else if (req0 || req1) begin
                if (req0 && req1) m_port = (P_RR != 0) ? ~m_last : 1'b0;
                else              m_port = req1;
                m_last   = m_port;
                m_w      = m_port ? w1 : w0;
                m_addr   = m_port ? addr1 : addr0;
                m_wdata  = m_port ? wdata1 : wdata0;
                m_acc    = k + 1;
                m_ack    = k + 2 + (m_w ? 0 : P_LAT);
                m_active = 1'b1;
            end
        end

        always @(negedge clk) begin
            logic in_acc, in_ack;
            if (cyc >= 1) begin
                in_acc = m_active && (cyc == m_acc);
                in_ack = m_active && (cyc == m_ack);
                check_bit("cs", gi, cs, in_acc);
                check_bit("dm_w", gi, wr, in_acc && m_w);
                check_bit("dm_r", gi, rd, in_acc && !m_w);
                check("dm_addr", gi, dm_addr, m_addr);
                check("dm_wdata", gi, dm_wdata, m_wdata);
                check_bit("ack0", gi, ack0, in_ack && !m_port);
                check_bit("ack1", gi, ack1, in_ack && m_port);
                check("rdata0", gi, rdata0, m_rd[0]);
                check("rdata1", gi, rdata1, m_rd[1]);
                check_bit("busy", gi, busy, m_active);
                if (ack0 || ack1)
                    $display("inst%0d cyc%0d: port%0d %s addr 0x%08h done",
                             gi, cyc, ack1 ? 1 : 0, m_w ? "write" : "read", m_addr);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int seq[$];
        int c0, c1;
        rstn = 1'b0;
        req0 = 1'b0; req1 = 1'b0; w0 = 1'b0; w1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

        tick(3);
        check_bit("rst_busy", 0, busy_v[0], 1'b0);
        check("rst_rdata0", 0, rdata0_v[0], 32'h0);
        check("rst_addr", 0, dm_addr_v[0], 32'h0);
        rstn = 1'b1;
        tick(2);

        // Port 0 write 0x100 <- 0xDEADBEEF
        req0 = 1'b1; w0 = 1'b1; addr0 = 32'h100; wdata0 = 32'hDEADBEEF;
        tick(1);
        check_bit("wr_cs", 0, cs_v[0], 1'b1);
        check_bit("wr_w", 0, w_v[0], 1'b1);
        check_bit("wr_r", 0, r_v[0], 1'b0);
        check("wr_addr", 0, dm_addr_v[0], 32'h100);
        check("wr_wdata", 0, dm_wdata_v[0], 32'hDEADBEEF);
        check_bit("wr_ack_early", 0, ack0_v[0], 1'b0);
        tick(1);
        check_bit("wr_ack", 0, ack0_v[0], 1'b1);
        check_bit("wr_ack_lat3", 2, ack0_v[2], 1'b1);
        req0 = 1'b0;
        tick(1);
        check_bit("wr_ack_late", 0, ack0_v[0], 1'b0);
        tick(6);

        // Port 1 read 0x100
        req1 = 1'b1; w1 = 1'b0; addr1 = 32'h100;
        tick(1);
        check_bit("rd_strobe", 0, r_v[0], 1'b1);
        tick(1);
        check_bit("rd_ack_early", 0, ack1_v[0], 1'b0);
        tick(1);
        check_bit("rd_ack", 0, ack1_v[0], 1'b1);
        check("rd_data", 0, rdata1_v[0], 32'hDEADBEEF);
        check("rd_other", 0, rdata0_v[0], 32'h0);
        check_bit("rd_ack_fixed", 1, ack1_v[1], 1'b1);
        req1 = 1'b0;
        tick(1);
        check_bit("rd3_ack_early", 2, ack1_v[2], 1'b0);
        tick(1);
        check_bit("rd3_ack", 2, ack1_v[2], 1'b1);
        check("rd3_data", 2, rdata1_v[2], 32'hDEADBEEF);
        tick(4);

        // Both ports requesting writes continuously
        req0 = 1'b1; w0 = 1'b1; addr0 = 32'h10; wdata0 = 32'h1111_1111;
        req1 = 1'b1; w1 = 1'b1; addr1 = 32'h20; wdata1 = 32'h2222_2222;
        c0 = 0; c1 = 0;
        for (int i = 1; i <= 11; i++) begin
            tick(1);
            if (ack0_v[0]) seq.push_back(0);
            if (ack1_v[0]) seq.push_back(1);
            if (ack0_v[1]) c0++;
            if (ack1_v[1]) c1++;
        end
        check("rr_count", 0, 32'(seq.size()), 32'd4);
        for (int i = 0; i < 4 && i < seq.size(); i++)
            check("rr_order", 0, 32'(seq[i]), 32'(i % 2));
        check("fixed_ack0", 1, 32'(c0), 32'd4);
        check("fixed_ack1", 1, 32'(c1), 32'd0);
        req0 = 1'b0; req1 = 1'b0;
        tick(8);

        // Read on port 0, reset while the slow configuration is in WAIT
        req0 = 1'b1; w0 = 1'b0; addr0 = 32'h200;
        tick(2);
        rstn = 1'b0; req0 = 1'b0;
        tick(1);
        check_bit("rst_mid_busy", 2, busy_v[2], 1'b0);
        check_bit("rst_mid_ack", 2, ack0_v[2], 1'b0);
        check("rst_mid_rdata1", 2, rdata1_v[2], 32'h0);
        check("rst_mid_rdata1_l1", 0, rdata1_v[0], 32'h0);
        tick(1);
        rstn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            check_bit("rst_no_ack", 2, ack0_v[2], 1'b0);
        end

        // Mixed directed traffic
        for (int i = 0; i < 60; i++) begin
            req0   = (i % 5) != 4;
            req1   = (i % 3) != 1;
            w0     = i[0];
            w1     = (i % 4) < 2;
            addr0  = 32'h1000 + 32'((i % 8) * 4);
            addr1  = 32'h1000 + 32'(((i + 3) % 8) * 4);
            wdata0 = 32'hA000_0000 ^ 32'(i);
            wdata1 = 32'hB000_0000 ^ 32'(i * 7);
            tick(1);
        end
        req0 = 1'b0; req1 = 1'b0;
        tick(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
